mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the CPU instruction fetch path (imem_*) and the load/store path (dmem_*).
- Arbitrates requests from the two sides and runs a req/ack handshake with the memory, which has variable latency.
- Returns a one-cycle good strobe with read data to whichever side was served.
- Sits between the cpu core and the unified memory model/controller.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- DMEM_PRIORITY, 0, 0 = round-robin on contention; 1 = dmem always wins
- TIMEOUT_CYCLES, 255, memory cycles allowed before timeout abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_valid  in  1  fetch request, held until imem_good
- imem_addr  in  ADDR_W  fetch address
- imem_good  out  1  one-cycle pulse, fetch complete
- imem_instr  out  DATA_W  fetched word, valid while imem_good=1
- dmem_valid  in  1  load/store request, held until dmem_good
- dmem_addr  in  ADDR_W  load/store address
- dmem_writeData  in  DATA_W  store data
- dmem_memRead  in  1  load
- dmem_memWrite  in  1  store
- dmem_maskMode  in  2  byte/half/word select, passed through
- dmem_sext  in  1  sign-extend select, passed through
- dmem_good  out  1  one-cycle pulse, load/store complete
- dmem_readData  out  DATA_W  load data, valid while dmem_good=1
- mem_req  out  1  memory request, held until mem_ack
- mem_addr  out  ADDR_W
- mem_wdata  out  DATA_W
- mem_we  out  1
- mem_re  out  1
- mem_maskMode  out  2
- mem_sext  out  1
- mem_ack  in  1  memory done; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W
- arb_err  out  1  one-cycle pulse with good on a timeout abort

Behaviour:

Reset:
- reset_n=0 drives every output to 0 immediately, including mem_req mid-transaction.
- Reset also sets FSM=IDLE, last_grant=IMEM and clears the timeout counter.

Request eligibility:
- imem is eligible when imem_valid=1.
- dmem is eligible when dmem_valid=1 and (dmem_memRead | dmem_memWrite).
- If dmem_memRead and dmem_memWrite are both 1, the store wins: mem_we=1, mem_re=0.
- imem transactions always drive mem_re=1, mem_we=0, mem_maskMode=2'b10, mem_sext=0.

FSM (IDLE, BUSY_I, BUSY_D, RESP):
- IDLE: if any side is eligible, pick a winner, register its address, data and controls onto mem_*, set mem_req=1, and go to BUSY_I or BUSY_D.
- Contention with DMEM_PRIORITY=0: the side that is not last_grant wins.
- Contention with DMEM_PRIORITY=1: dmem wins.
- last_grant is updated at every grant.
- BUSY_x: mem_* held stable. When mem_ack=1, capture mem_rdata into the winner's data output, drop mem_req, and go to RESP.
- RESP: the winner's good=1 for exactly this cycle, then return to IDLE. Valid inputs are not sampled in RESP, so a stale valid cannot be re-granted.

Timing:
- Minimum latency: valid seen at edge N → mem_req=1 after edge N. With mem_ack in that cycle, good=1 after edge N+1 and the arbiter is back in IDLE after N+2.
- The arbiter can issue one new grant every 3 cycles at most.
- Data outputs hold their last value outside good and are not cleared.
- A requester dropping valid while its transaction is in BUSY_x does not abort it; good is still issued.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears at grant and increments each BUSY_x cycle without mem_ack. When it reaches TIMEOUT_CYCLES, drop mem_req, drive the winner's data output to 0, and go to RESP. In RESP, good=1 and arb_err=1 together.
- mem_ack arriving in the same cycle as the timeout is a normal completion (ack wins).
- Not defined: the counter is absent, BUSY_x waits indefinitely, and arb_err is tied to 0.

Test Plan:
- Single fetch: imem_valid=1, addr=0x10; memory acks after 3 cycles with 0x00A00093 → mem_re=1, mem_addr=0x10; imem_good pulses 1 cycle with imem_instr=0x00A00093.
- Store: dmem_memWrite=1, addr=0x40, data=0xDEADBEEF, mask=2'b01 → mem_we=1, mem_wdata=0xDEADBEEF, mem_maskMode=01; dmem_good pulses once; imem_good stays 0.
- Contention, DMEM_PRIORITY=0: both sides held valid continuously after reset → grants go D, I, D, I; each good is exactly 1 cycle; no double grant per request.
- Contention, DMEM_PRIORITY=1: both sides held valid → dmem granted every time; imem_good stays 0 until dmem_valid drops.
- Reset mid-op: reset_n low during BUSY_D → mem_req=0 in the same cycle without waiting for a clock edge; after release, the first contended grant goes to dmem.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: mem_ack never asserted → mem_req drops after 4 busy cycles; imem_good=1, arb_err=1, imem_instr=0. Without the macro, mem_req stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (imem) and load/store (dmem) requests onto one variable-latency memory port.
// Optional MEM_ARB_TIMEOUT_EN adds a busy-cycle watchdog that aborts a stalled transaction and flags arb_err.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DMEM_PRIORITY  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              imem_valid,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic              imem_good,
  output logic [DATA_W-1:0] imem_instr,
  input  logic              dmem_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_writeData,
  input  logic              dmem_memRead,
  input  logic              dmem_memWrite,
  input  logic [1:0]        dmem_maskMode,
  input  logic              dmem_sext,
  output logic              dmem_good,
  output logic [DATA_W-1:0] dmem_readData,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [1:0]        mem_maskMode,
  output logic              mem_sext,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, RESP = 2'd3} state_t;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

  state_t state_r;
  grant_t last_grant_r;
  logic   imem_elig_s;
  logic   dmem_elig_s;
  logic   pick_d_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
`else
  // Keeps the timeout parameter referenced when the watchdog is compiled out.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Request eligibility and winner selection for the IDLE grant.
  always_comb begin
    imem_elig_s = imem_valid;
    dmem_elig_s = dmem_valid & (dmem_memRead | dmem_memWrite);
    if (imem_elig_s && dmem_elig_s) begin
      pick_d_s = (DMEM_PRIORITY != 0) || (last_grant_r == GRANT_I);
    end else begin
      pick_d_s = dmem_elig_s;
    end
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      last_grant_r  <= GRANT_I;
      imem_good     <= 1'b0;
      imem_instr    <= '0;
      dmem_good     <= 1'b0;
      dmem_readData <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_maskMode  <= 2'b00;
      mem_sext      <= 1'b0;
      arb_err       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt_r     <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (imem_elig_s || dmem_elig_s) begin
            mem_req <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
            if (pick_d_s) begin
              mem_addr     <= dmem_addr;
              mem_wdata    <= dmem_writeData;
              mem_we       <= dmem_memWrite;
              mem_re       <= dmem_memRead & ~dmem_memWrite;
              mem_maskMode <= dmem_maskMode;
              mem_sext     <= dmem_sext;
              last_grant_r <= GRANT_D;
              state_r      <= BUSY_D;
            end else begin
              mem_addr     <= imem_addr;
              mem_wdata    <= '0;
              mem_we       <= 1'b0;
              mem_re       <= 1'b1;
              mem_maskMode <= 2'b10;
              mem_sext     <= 1'b0;
              last_grant_r <= GRANT_I;
              state_r      <= BUSY_I;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack in the timeout cycle still counts as a normal completion.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_r <= RESP;
            if (state_r == BUSY_D) begin
              dmem_readData <= mem_rdata;
              dmem_good     <= 1'b1;
            end else begin
              imem_instr <= mem_rdata;
              imem_good  <= 1'b1;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            mem_req <= 1'b0;
            arb_err <= 1'b1;
            state_r <= RESP;
            if (state_r == BUSY_D) begin
              dmem_readData <= '0;
              dmem_good     <= 1'b1;
            end else begin
              imem_instr <= '0;
              imem_good  <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
`else
          else begin
            state_r <= state_r;
          end
`endif
        end
        RESP: begin
          imem_good <= 1'b0;
          dmem_good <= 1'b0;
          arb_err   <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
